// File: rtl/pipe_mem_arb.sv
// pipe_mem_arb: shares one single-port synchronous RAM between the
// instruction-fetch port (read-only) and the memory-stage port (read/write).
// Each access runs IDLE -> ISSUE -> [WAIT x RD_LAT] -> ACK.
// MEM normally beats IF. Define PIPE_MEM_ARB_FAIR_EN to add a starvation
// counter that hands IF one grant after STARVE_MAX MEM wins taken while IF
// was waiting.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner
// ISSUE | ram_en high for one cycle (write lands here)
// WAIT  | read latency countdown; capture ram_rdata when count hits 1
// ACK   | one-cycle completion pulse to the owner

module pipe_mem_arb #(
  parameter int DW         = 32,
  parameter int AW         = 10,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("pipe_mem_arb: RD_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("pipe_mem_arb: STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;        // 1 = MEM owns the access, 0 = IF
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          grant_mem, grant_if;

`ifdef PIPE_MEM_ARB_FAIR_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  // Count MEM wins taken while IF was also asking; any IF win clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (grant_mem && if_req) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Winner selection: MEM first, except when IF has been starved long enough.
  always_comb begin
    grant_mem = mem_req;
    grant_if  = if_req & ~mem_req;
`ifdef PIPE_MEM_ARB_FAIR_EN
    if (mem_req && if_req && (starve_q >= STARVE_LIM)) begin
      grant_mem = 1'b0;
      grant_if  = 1'b1;
    end
`endif
  end

  // Next-state and datapath next values; ram_en/ram_we default low so they
  // are high only during ISSUE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          owner_d     = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          state_d     = S_ISSUE;
        end else if (grant_if) begin
          owner_d    = 1'b0;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ram_we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = RD_LAT_C;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (owner_q) begin
            mem_rdata_d = ram_rdata;
          end else begin
            if_rdata_d = ram_rdata;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = (state_q == S_ACK) & ~owner_q;
  assign mem_ack   = (state_q == S_ACK) & owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Directed bench for pipe_mem_arb: a table of single transactions against a
// RAM model, then hand-written sequences for simultaneous requests, RD_LAT=3,
// reset during an access, and the grant order under continuous contention.
// Cycle 0 of a transaction is the cycle in which the arbiter (in IDLE) first
// sees the request; outputs are sampled on the falling edge.

module tb_pipe_mem_arb;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // RD_LAT=1 instance with a behavioural RAM
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr, ram_addr;
  logic [DW-1:0] mem_wdata, ram_rdata, ram_wdata, if_rdata, mem_rdata;
  logic          if_ack, mem_ack, ram_en, ram_we, busy;

  // RD_LAT=3 instance; its RAM data is a per-cycle pattern
  logic          b_if_req, b_mem_req, b_mem_we;
  logic [AW-1:0] b_if_addr, b_mem_addr, b_ram_addr;
  logic [DW-1:0] b_mem_wdata, b_ram_rdata, b_ram_wdata, b_if_rdata, b_mem_rdata;
  logic          b_if_ack, b_mem_ack, b_ram_en, b_ram_we, b_busy;

  int n_chk = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  pipe_mem_arb #(.DW(DW), .AW(AW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  pipe_mem_arb #(.DW(DW), .AW(AW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clock(clock), .resetn(resetn),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  always @(posedge clock) cyc <= cyc + 1;
  assign b_ram_rdata = 32'hA000_0000 + cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int we_cnt;
    bit other_ack;
    logic [31:0] other_before;
    logic [31:0] rd;
    lat = -1; we_cnt = 0; other_ack = 1'b0; rd = '0;
    @(posedge clock); #1;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      other_before = if_rdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      other_before = mem_rdata;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (ram_we) we_cnt++;
      if (c == 1) begin
        chk({tag, " ram_en@1"}, 32'(ram_en), 32'd1);
        chk({tag, " ram_addr@1"}, 32'(ram_addr), 32'(v.addr));
      end
      if (v.is_mem ? if_ack : mem_ack) other_ack = 1'b1;
      if (v.is_mem ? mem_ack : if_ack) begin
        lat = c;
        rd = v.is_mem ? mem_rdata : if_rdata;
        break;
      end
      @(posedge clock); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    if (!v.we) chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " ram_we cycles"}, 32'(we_cnt), 32'(v.we));
    chk({tag, " other ack"}, 32'(other_ack), 32'd0);
    chk({tag, " other rdata held"}, v.is_mem ? if_rdata : mem_rdata, other_before);
    @(posedge clock); #1;
    mem_req = 1'b0; if_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mem_c, if_c, lat, n;
    bit if_changed, bad;
    logic [31:0] prev_if, if_rd, mem_rd, rd;
    int unsigned c0;
    bit seq[6];
    bit exp_seq[6];

    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_we = 0; b_mem_addr = '0; b_mem_wdata = '0;

    vecs[0] = '{1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0,        2};
    vecs[1] = '{1'b0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF, 3};
    vecs[2] = '{1'b1, 1'b1, 10'h3FF, 32'h12345678, 32'h0,        2};
    vecs[3] = '{1'b0, 1'b0, 10'h3FF, 32'h0,        32'h12345678, 3};
    vecs[4] = '{1'b1, 1'b1, 10'h010, 32'h11111111, 32'h0,        2};
    vecs[5] = '{1'b1, 1'b1, 10'h020, 32'h22222222, 32'h0,        2};
    vecs[6] = '{1'b1, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF, 3};
    vecs[7] = '{1'b1, 1'b1, 10'h000, 32'hA5A5A5A5, 32'h0,        2};
    vecs[8] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'hA5A5A5A5, 3};

    // reset state
    #12;
    chk("rst if_ack", 32'(if_ack), 32'd0);
    chk("rst mem_ack", 32'(mem_ack), 32'd0);
    chk("rst ram_en", 32'(ram_en), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // table of single transactions
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    @(negedge clock);
    chk("idle busy", 32'(busy), 32'd0);

    // simultaneous MEM read 0x010 and IF read 0x020
    prev_if = if_rdata;
    mem_c = -1; if_c = -1; if_changed = 1'b0; if_rd = '0; mem_rd = '0;
    @(posedge clock); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h010;
    if_req = 1'b1; if_addr = 10'h020;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (mem_ack && mem_c < 0) begin mem_c = c; mem_rd = mem_rdata; end
      if (if_ack && if_c < 0) begin
        if_c = c; if_rd = if_rdata;
      end else if (if_rdata !== prev_if) begin
        if_changed = 1'b1;
      end
      @(posedge clock); #1;
      if (mem_c == c) mem_req = 1'b0;
      if (if_c == c) begin if_req = 1'b0; break; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("simul mem_ack cycle", 32'(mem_c), 32'd3);
    chk("simul mem_rdata", mem_rd, 32'h11111111);
    chk("simul if_ack cycle", 32'(if_c), 32'd7);
    chk("simul if_rdata", if_rd, 32'h22222222);
    chk("simul if_rdata held", 32'(if_changed), 32'd0);

    // RD_LAT=3: data is whatever the RAM shows on the third WAIT cycle
    lat = -1; rd = '0; bad = 1'b0;
    @(posedge clock); #1;
    b_if_req = 1'b1; b_if_addr = 10'h123; c0 = cyc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (c == 1) chk("lat3 ram_en@1", 32'(b_ram_en), 32'd1);
      if (b_mem_ack) bad = 1'b1;
      if (b_if_ack) begin lat = c; rd = b_if_rdata; break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    b_if_req = 1'b0;
    chk("lat3 latency", 32'(lat), 32'd5);
    chk("lat3 rdata", rd, 32'hA000_0000 + c0 + 4);
    chk("lat3 mem_ack", 32'(bad), 32'd0);
    chk("lat3 mem_rdata", b_mem_rdata, 32'd0);

    // reset while in WAIT, then the held IF request completes
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 10'h005;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("wait busy before rst", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("wait rst ram_en", 32'(ram_en), 32'd0);
    chk("wait rst if_ack", 32'(if_ack), 32'd0);
    chk("wait rst mem_ack", 32'(mem_ack), 32'd0);
    chk("wait rst busy", 32'(busy), 32'd0);
    chk("wait rst if_rdata", if_rdata, 32'd0);
    chk("wait rst mem_rdata", mem_rdata, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    lat = -1; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (if_ack) begin lat = c; rd = if_rdata; break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    if_req = 1'b0;
    chk("post rst if latency", 32'(lat), 32'd3);
    chk("post rst if_rdata", rd, 32'hDEADBEEF);

    // reset during ISSUE of a write drops ram_en/ram_we at once
    @(posedge clock); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h200; mem_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    @(negedge clock);
    chk("issue ram_we", 32'(ram_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("issue rst ram_en", 32'(ram_en), 32'd0);
    chk("issue rst ram_we", 32'(ram_we), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;

    // both requesters held high: record the order of grants
    n = 0;
    @(posedge clock); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h005;
    if_req = 1'b1; if_addr = 10'h3FF;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (mem_ack)     begin seq[n] = 1'b1; n++; end
      else if (if_ack) begin seq[n] = 1'b0; n++; end
      if (n == 6) break;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    mem_req = 1'b0; if_req = 1'b0;
`ifdef PIPE_MEM_ARB_FAIR_EN
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("grant count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) chk($sformatf("grant%0d owner(1=MEM)", i), 32'(seq[i]), 32'(exp_seq[i]));
    end

    repeat (4) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
